// File: rtl/native_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus.
// One transaction in flight; a watchdog completes hung transactions with ERR_DATA.
module native_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        sys_clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    input  logic        err_clr,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic        busy
);

    localparam int unsigned     CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic              grant;
    logic              prio;
    logic [CNT_W-1:0]  count;

    logic              in_grant;
    logic              g_valid;
    logic [31:0]       g_addr;
    logic [31:0]       g_wdata;
    logic [3:0]        g_wstrb;
    logic [31:0]       g_rdata;
    logic              slave_done;
    logic              timeout_hit;
    logic              complete;

    // Datapath muxing toward the slave and back to the granted master.
    always_comb begin
        in_grant    = (state == GRANT);
        g_valid     = grant ? m1_valid : m0_valid;
        g_addr      = grant ? m1_addr  : m0_addr;
        g_wdata     = grant ? m1_wdata : m0_wdata;
        g_wstrb     = grant ? m1_wstrb : m0_wstrb;

        s_valid     = in_grant && g_valid;
        s_addr      = s_valid ? g_addr  : 32'h0;
        s_wdata     = s_valid ? g_wdata : 32'h0;
        s_wstrb     = s_valid ? g_wstrb : 4'h0;

        // A slave response in the final watchdog cycle takes precedence.
        slave_done  = s_valid && s_ready;
        timeout_hit = s_valid && !s_ready && (count == CNT_LAST);
        complete    = slave_done || timeout_hit;
        g_rdata     = timeout_hit ? ERR_DATA : s_rdata;

        m0_ready    = complete && !grant;
        m1_ready    = complete && grant;
        m0_rdata    = (in_grant && !grant) ? g_rdata : 32'h0;
        m1_rdata    = (in_grant && grant)  ? g_rdata : 32'h0;
        busy        = in_grant;
    end

    // Arbitration FSM, watchdog counter and sticky error capture.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 1'b0;
            prio     <= 1'b0;
            count    <= '0;
            err_flag <= 1'b0;
            err_addr <= 32'h0;
        end else begin
            if (timeout_hit) begin
                err_flag <= 1'b1;
                if (!err_flag) begin
                    err_addr <= g_addr;
                end
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    count <= '0;
                    if (m0_valid || m1_valid) begin
                        grant <= (m0_valid && m1_valid) ? prio : m1_valid;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!g_valid) begin
                        // Master withdrew its request: drop it without touching priority.
                        state <= IDLE;
                        count <= '0;
                    end else if (complete) begin
                        state <= IDLE;
                        prio  <= ~grant;
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_native_bus_arbiter.sv
// Bench for native_bus_arbiter: directed scenarios then randomized traffic
// checked against a transaction-level model of grant order, latency and errors.
module tb_native_bus_arbiter;

    localparam int unsigned TMO = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err_clr, err_flag, busy;
    logic [31:0] err_addr;

    int passed = 0;
    int total  = 0;

    native_bus_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    // Acts as the slave for one transaction: responds lat cycles after s_valid rises.
    // Returns which master got ready, its rdata, the GRANT cycle of completion and the slave-side fields.
    task automatic run_txn(input int lat, input logic [31:0] data,
                           output int who, output int cyc, output logic [31:0] rd,
                           output logic [31:0] sa, output logic [31:0] sw, output logic [3:0] ss);
        bit seen = 0;
        who = -1; cyc = 0; rd = 32'h0; sa = 32'h0; sw = 32'h0; ss = 4'h0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (s_valid) seen = 1;
            else step();
        end
        if (!seen) begin
            chk("s_valid_wait", 32'(s_valid), 32'h1);
            return;
        end
        sa = s_addr; sw = s_wdata; ss = s_wstrb;
        for (int g = 1; g <= 24; g++) begin
            s_ready = (g == lat + 1);
            s_rdata = (g == lat + 1) ? data : $urandom;
            #1;
            if (m0_ready || m1_ready) begin
                chk("dual_ready", 32'(m0_ready & m1_ready), 32'h0);
                who = m1_ready ? 1 : 0;
                rd  = m1_ready ? m1_rdata : m0_rdata;
                cyc = g;
                break;
            end
            step();
        end
        @(negedge sys_clk);
        s_ready = 1'b0;
        if (who == 0) m0_valid = 1'b0;
        if (who == 1) m1_valid = 1'b0;
        #1;
        chk("gap_s_valid", 32'(s_valid), 32'h0);
        chk("gap_ready", 32'({m0_ready, m1_ready}), 32'h0);
    endtask

    // Transaction-level reference state.
    bit          mdl_prio;
    bit          mdl_errf;
    logic [31:0] mdl_erra;

    int          who, cyc;
    logic [31:0] rd, sa, sw;
    logic [3:0]  ss;

    initial begin
        reset = 1'b1; err_clr = 1'b0;
        m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        s_ready = 1'b0; s_rdata = 32'h0;
        step(); step();
        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err_flag", 32'(err_flag), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_ready", 32'({m0_ready, m1_ready}), 32'h0);
        reset = 1'b0;
        step();

        // m0 read, slave answers two cycles after s_valid rises
        m0_valid = 1'b1; m0_addr = 32'h4000; m0_wstrb = 4'h0;
        run_txn(2, 32'h1234_5678, who, cyc, rd, sa, sw, ss);
        chk("t1_who", 32'(who), 32'h0);
        chk("t1_cycle", 32'(cyc), 32'd3);
        chk("t1_rdata", rd, 32'h1234_5678);
        chk("t1_s_addr", sa, 32'h4000);

        // simultaneous requests after reset: m0 wins, then m1, then m0 again
        reset = 1'b1; step(); reset = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h100;
        m1_valid = 1'b1; m1_addr = 32'h200;
        step();
        run_txn(1, 32'hA, who, cyc, rd, sa, sw, ss);
        chk("t2_first_who", 32'(who), 32'h0);
        chk("t2_first_addr", sa, 32'h100);
        run_txn(1, 32'hB, who, cyc, rd, sa, sw, ss);
        chk("t2_second_who", 32'(who), 32'h1);
        chk("t2_second_addr", sa, 32'h200);
        m0_valid = 1'b1; m1_valid = 1'b1;
        run_txn(0, 32'hC, who, cyc, rd, sa, sw, ss);
        chk("t2_rereq_who", 32'(who), 32'h0);
        run_txn(0, 32'hD, who, cyc, rd, sa, sw, ss);
        chk("t2_rereq_tail_who", 32'(who), 32'h1);

        // m1 write passes data and strobes unchanged
        m1_valid = 1'b1; m1_addr = 32'h8010; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0101;
        run_txn(1, 32'h0, who, cyc, rd, sa, sw, ss);
        chk("t3_who", 32'(who), 32'h1);
        chk("t3_wdata", sw, 32'hCAFE_F00D);
        chk("t3_wstrb", 32'(ss), 32'h5);

        // watchdog: two timeouts, only the first address is kept, then clear
        m1_valid = 1'b1; m1_addr = 32'h1_8200; m1_wstrb = 4'h0;
        run_txn(100, 32'h0, who, cyc, rd, sa, sw, ss);
        chk("t4_who", 32'(who), 32'h1);
        chk("t4_cycle", 32'(cyc), 32'(TMO));
        chk("t4_rdata", rd, ERR);
        chk("t4_err_flag", 32'(err_flag), 32'h1);
        chk("t4_err_addr", err_addr, 32'h1_8200);
        m0_valid = 1'b1; m0_addr = 32'h3_0000;
        run_txn(100, 32'h0, who, cyc, rd, sa, sw, ss);
        chk("t4_second_rdata", rd, ERR);
        chk("t4_err_addr_kept", err_addr, 32'h1_8200);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t4_err_cleared", 32'(err_flag), 32'h0);

        // slave ready on the last watchdog cycle wins
        m0_valid = 1'b1; m0_addr = 32'h500;
        run_txn(int'(TMO) - 1, 32'h55, who, cyc, rd, sa, sw, ss);
        chk("t5_cycle", 32'(cyc), 32'(TMO));
        chk("t5_rdata", rd, 32'h55);
        chk("t5_err_flag", 32'(err_flag), 32'h0);

        // reset while the slave is stalled; pending m1 is served promptly afterwards
        m0_valid = 1'b1; m0_addr = 32'h600;
        m1_valid = 1'b1; m1_addr = 32'h700;
        step(); step(); step(); step();
        chk("t6_granted_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        step();
        chk("t6_s_valid", 32'(s_valid), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_ready", 32'({m0_ready, m1_ready}), 32'h0);
        reset = 1'b0; m0_valid = 1'b0;
        step(); step();
        chk("t6_m1_granted", 32'(s_valid), 32'h1);
        chk("t6_m1_addr", s_addr, 32'h700);
        run_txn(0, 32'h77, who, cyc, rd, sa, sw, ss);
        chk("t6_m1_rdata", rd, 32'h77);

        // randomized traffic against the transaction model
        mdl_prio = 1'b0; mdl_errf = 1'b0; mdl_erra = 32'h0;
        for (int it = 0; it < 40; it++) begin
            int          req;
            int          order[$];
            logic [31:0] addr_m[2];
            logic [31:0] wd_m[2];
            logic [3:0]  ws_m[2];
            req = int'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                addr_m[m] = $urandom & 32'hFFFF_FFFC;
                wd_m[m]   = $urandom;
                ws_m[m]   = 4'($urandom);
            end
            m0_addr = addr_m[0]; m0_wdata = wd_m[0]; m0_wstrb = ws_m[0];
            m1_addr = addr_m[1]; m1_wdata = wd_m[1]; m1_wstrb = ws_m[1];
            m0_valid = req[0]; m1_valid = req[1];
            order.delete();
            if (req == 3) begin
                order.push_back(int'(mdl_prio));
                order.push_back(int'(!mdl_prio));
            end else begin
                order.push_back(req == 2 ? 1 : 0);
            end
            foreach (order[k]) begin
                int          m;
                int          lat;
                logic [31:0] data;
                bit          tmo;
                m    = order[k];
                lat  = int'($urandom_range(0, 19));
                data = $urandom;
                tmo  = (lat + 1 > int'(TMO));
                run_txn(lat, data, who, cyc, rd, sa, sw, ss);
                chk("rnd_who", 32'(who), 32'(m));
                chk("rnd_addr", sa, addr_m[m]);
                chk("rnd_wdata", sw, wd_m[m]);
                chk("rnd_wstrb", 32'(ss), 32'(ws_m[m]));
                chk("rnd_cycle", 32'(cyc), tmo ? 32'(TMO) : 32'(lat + 1));
                chk("rnd_rdata", rd, tmo ? ERR : data);
                mdl_prio = (m == 0);
                if (tmo) begin
                    if (!mdl_errf) mdl_erra = addr_m[m];
                    mdl_errf = 1'b1;
                end
                chk("rnd_err_flag", 32'(err_flag), 32'(mdl_errf));
                chk("rnd_err_addr", err_addr, mdl_erra);
            end
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1; step(); err_clr = 1'b0;
                mdl_errf = 1'b0;
                chk("rnd_err_clr", 32'(err_flag), 32'h0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
